// File: rtl/noc_tx_arbiter_if.sv
// Request/injection bundle between per-core NI FIFOs, the tx arbiter and the router input port.
// master = arbiter side, slave = requesters/router side.
interface noc_tx_arbiter_if #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned IDX_W      = $clog2(NUM_PORTS)
) ();

    logic [NUM_PORTS-1:0]            req_empty;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_data;
    logic [NUM_PORTS-1:0]            req_rd_en;
    logic                            out_valid;
    logic [DATA_WIDTH-1:0]           out_data;
    logic [IDX_W-1:0]                out_src;
    logic                            out_ready;
    logic [15:0]                     pkt_count;

    modport master (
        input  req_empty,
        input  req_data,
        input  out_ready,
        output req_rd_en,
        output out_valid,
        output out_data,
        output out_src,
        output pkt_count
    );

    modport slave (
        output req_empty,
        output req_data,
        output out_ready,
        input  req_rd_en,
        input  out_valid,
        input  out_data,
        input  out_src,
        input  pkt_count
    );

endinterface

// File: rtl/noc_tx_arbiter.sv
// Round-robin arbiter sharing one router injection link between NUM_PORTS NI FIFOs.
// Optional macro NOC_ARB_PORT0_PRIO_EN makes port 0 strict-priority over the round-robin ports.
module noc_tx_arbiter #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned IDX_W      = $clog2(NUM_PORTS)
) (
    input logic                clk,
    input logic                reset,
    noc_tx_arbiter_if.master   bus
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [IDX_W-1:0]        src_q, src_d;
    logic [15:0]             cnt_q, cnt_d;

    logic [NUM_PORTS-1:0]    rr_cand;
    logic                    win_vld;
    logic [IDX_W-1:0]        win_idx;
    logic                    rr_upd;
    logic                    load_opp;
    logic                    accept;
    logic [NUM_PORTS-1:0]    rd_en;

    // Winner: first candidate at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned      p;
        logic [IDX_W-1:0] pi;
        rr_cand = ~bus.req_empty;
`ifdef NOC_ARB_PORT0_PRIO_EN
        rr_cand[0] = 1'b0;
`endif
        win_vld = 1'b0;
        win_idx = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            p = 32'(rr_ptr_q) + k;
            if (p >= NUM_PORTS) begin
                p = p - NUM_PORTS;
            end
            pi = IDX_W'(p);
            if (!win_vld && rr_cand[pi]) begin
                win_vld = 1'b1;
                win_idx = pi;
            end
        end
        rr_upd = 1'b1;
`ifdef NOC_ARB_PORT0_PRIO_EN
        if (!bus.req_empty[0]) begin
            win_vld = 1'b1;
            win_idx = '0;
            rr_upd  = 1'b0;
        end
`endif
    end

    // Next-state and pop strobe.
    always_comb begin
        int unsigned nxt;
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        src_d    = src_q;
        rd_en    = '0;
        nxt      = 32'(win_idx) + 1;
        if (nxt >= NUM_PORTS) begin
            nxt = 0;
        end

        load_opp = (state_q == StIdle) || ((state_q == StSend) && bus.out_ready);
        accept   = (state_q == StSend) && bus.out_ready;
        cnt_d    = cnt_q + 16'(accept);

        unique case (state_q)
            StIdle: begin
                if (win_vld) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (bus.out_ready && !win_vld) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load_opp && win_vld) begin
            data_d = bus.req_data[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
            src_d  = win_idx;
            if (rr_upd) begin
                rr_ptr_d = IDX_W'(nxt);
            end
            // Reset is async; keep the combinational pop from leaking while it is held.
            if (!reset) begin
                rd_en[win_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            data_q   <= '0;
            src_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            src_q    <= src_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.req_rd_en = rd_en;
    assign bus.out_valid = (state_q == StSend);
    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;
    assign bus.pkt_count = cnt_q;

    a_rd_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(bus.req_rd_en));

    a_rd_not_empty: assert property (@(posedge clk) disable iff (reset)
        (bus.req_rd_en & bus.req_empty) == '0);

    a_hold_stable: assert property (@(posedge clk) disable iff (reset)
        (bus.out_valid && !bus.out_ready) |=>
            (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_src)));

endmodule

// File: tb/tb_noc_tx_arbiter.sv
// Randomized and directed bench for noc_tx_arbiter against a queue-free behavioural model.
// Honours NOC_ARB_PORT0_PRIO_EN the same way the design does.
module tb_noc_tx_arbiter;

    localparam int unsigned NP = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 2;

    logic clk;
    logic reset;

    noc_tx_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .IDX_W(IW)) bus ();

    noc_tx_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .IDX_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a single output slot plus pointer and counter.
    bit          m_busy;
    logic [63:0] m_data;
    int          m_src;
    int          m_rr;
    int          m_cnt;

    logic [DW-1:0] heads [NP];
    int            last_grant;
    logic [NP-1:0] obs_rd;
    logic          obs_valid;
    logic [63:0]   obs_data;
    int            obs_src;
    int            obs_cnt;
    int            grants [8];
    int            exp_gr [8];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model_grant(input logic [NP-1:0] empty, input bit rdy);
        int p;
        if (m_busy && !rdy) return -1;
`ifdef NOC_ARB_PORT0_PRIO_EN
        if (!empty[0]) return 0;
`endif
        for (int k = 0; k < NP; k++) begin
            p = (m_rr + k) % NP;
`ifdef NOC_ARB_PORT0_PRIO_EN
            if (p == 0) continue;
`endif
            if (!empty[2'(p)]) return p;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_busy = 1'b0;
        m_data = '0;
        m_src  = 0;
        m_rr   = 0;
        m_cnt  = 0;
    endfunction

    // One clock: drive, compare against the model, then advance the model at the edge.
    task automatic step(input logic [NP-1:0] empty, input bit rdy);
        int            g;
        logic [NP-1:0] exp_rd;
        @(negedge clk);
        bus.req_empty = empty;
        bus.out_ready = rdy;
        for (int i = 0; i < NP; i++) bus.req_data[i*DW +: DW] = heads[i];
        #1;
        g = model_grant(empty, rdy);
        exp_rd = '0;
        if (g >= 0) exp_rd[2'(g)] = 1'b1;
        obs_rd    = bus.req_rd_en;
        obs_valid = bus.out_valid;
        obs_data  = bus.out_data;
        obs_src   = int'(bus.out_src);
        obs_cnt   = int'(bus.pkt_count);
        check_val("req_rd_en", 64'(obs_rd), 64'(exp_rd));
        check_val("out_valid", 64'(obs_valid), 64'(m_busy));
        if (m_busy) begin
            check_val("out_data", obs_data, m_data);
            check_val("out_src", 64'(obs_src), 64'(m_src));
        end
        check_val("pkt_count", 64'(obs_cnt), 64'(m_cnt));
        last_grant = g;
        @(posedge clk);
        if (m_busy && rdy) m_cnt = (m_cnt + 1) % 65536;
        if (g >= 0) begin
            m_busy = 1'b1;
            m_data = heads[g];
            m_src  = g;
`ifdef NOC_ARB_PORT0_PRIO_EN
            if (g != 0)
`endif
            m_rr = (g + 1) % NP;
        end else if (m_busy && rdy) begin
            m_busy = 1'b0;
        end
    endtask

    // Reset with requests pending and the router ready: nothing may be popped.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.req_empty = '0;
        bus.out_ready = 1'b1;
        #1;
        check_val("rst_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_count", 64'(bus.pkt_count), 64'd0);
        check_val("rst_rd_en", 64'(bus.req_rd_en), 64'd0);
        @(negedge clk);
        #1;
        check_val("rst_rd_en_hold", 64'(bus.req_rd_en), 64'd0);
        bus.req_empty = '1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1;
        bus.req_empty = '1;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < NP; i++) heads[i] = {$urandom, $urandom};
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check_val("init_valid", 64'(bus.out_valid), 64'd0);
        check_val("init_data", bus.out_data, 64'd0);
        check_val("init_src", 64'(bus.out_src), 64'd0);
        check_val("init_count", 64'(bus.pkt_count), 64'd0);
        check_val("init_rd_en", 64'(bus.req_rd_en), 64'd0);
        reset = 1'b0;

        // Single port 2, then drain.
        heads[2] = 64'h00000010_0000ABCD;
        step(4'b1011, 1'b1);
        check_val("sp_rd_en", 64'(obs_rd), 64'b0100);
        step(4'b1111, 1'b1);
        check_val("sp_valid", 64'(obs_valid), 64'd1);
        check_val("sp_data", obs_data, 64'h00000010_0000ABCD);
        check_val("sp_src", 64'(obs_src), 64'd2);
        step(4'b1111, 1'b1);
        check_val("sp_count", 64'(obs_cnt), 64'd1);
        check_val("drain_valid", 64'(obs_valid), 64'd0);

        // Reset while a packet is held.
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        check_val("pre_rst_valid", 64'(obs_valid), 64'd1);
        do_reset();

        // Fairness with all ports pending.
        for (int i = 0; i < 6; i++) begin
            heads[i % NP] = {$urandom, $urandom};
            step(4'b0000, 1'b1);
            grants[i] = last_grant;
`ifdef NOC_ARB_PORT0_PRIO_EN
            exp_gr[i] = 0;
`else
            exp_gr[i] = i % NP;
`endif
            check_val("fair_grant", 64'(grants[i]), 64'(exp_gr[i]));
            if (i > 0) check_val("fair_valid", 64'(obs_valid), 64'd1);
        end
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
        check_val("fair_count", 64'(obs_cnt), 64'd6);

        // Backpressure on a packet from port 1, then release into port 2.
        do_reset();
        step(4'b1101, 1'b1);
        check_val("bp_grant", 64'(last_grant), 64'd1);
        for (int i = 0; i < 5; i++) begin
            heads[1] = {$urandom, $urandom};
            heads[2] = {$urandom, $urandom};
            step(4'b1001, 1'b0);
            check_val("bp_src", 64'(obs_src), 64'd1);
            check_val("bp_rd_en", 64'(obs_rd), 64'd0);
        end
        step(4'b1001, 1'b1);
        check_val("bp_next_grant", 64'(last_grant), 64'd2);

        // Ports 0 and 3 only.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(4'b0110, 1'b1);
`ifdef NOC_ARB_PORT0_PRIO_EN
            check_val("p03_grant", 64'(last_grant), 64'd0);
`else
            check_val("p03_grant", 64'(last_grant), (i % 2 == 0) ? 64'd0 : 64'd3);
`endif
        end

        // Random traffic with one reset in the middle.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [NP-1:0] e;
            for (int i = 0; i < NP; i++) heads[i] = {$urandom, $urandom};
            e = NP'($urandom) | NP'($urandom);
            step(e, ($urandom_range(0, 3) != 0));
            if (c == 1500) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
